// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester (CPU data port, DMA copy engine) single-slave bus arbiter.
// Round-robin on ties, one transfer in flight, all outputs registered.
// Optional XFER timeout guarded by macro ARB_TIMEOUT_EN; when undefined the
// transfer waits for bus_ready indefinitely and bus_err is tied low.
//
// state | meaning
// IDLE  | arbitrate; latch winner's addr/we/wdata and raise strobe
// XFER  | strobe held until bus_ready (or timeout); capture read data
// DONE  | one-cycle ack to the granted requester, then back to IDLE
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_dma;
  logic [31:0] bus_addr_d, bus_wdata_d, cpu_rdata_d, dma_rdata_d;
  logic        bus_ren_d, bus_wen_d, cpu_ack_d, dma_ack_d;
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_d;
`endif

  // Next-state and next-output computation; registered below.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_dma    = 1'b0;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    bus_ren_d    = bus_ren;
    bus_wen_d    = bus_wen;
    cpu_rdata_d  = cpu_rdata;
    dma_rdata_d  = dma_rdata;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          // DMA wins only when alone or when the CPU had the previous grant.
          grant_dma    = dma_req && (!cpu_req || last_grant_q == GNT_CPU);
          last_grant_d = grant_dma ? GNT_DMA : GNT_CPU;
          bus_addr_d   = grant_dma ? dma_addr  : cpu_addr;
          bus_wdata_d  = grant_dma ? dma_wdata : cpu_wdata;
          bus_wen_d    = grant_dma ? dma_we    : cpu_we;
          bus_ren_d    = grant_dma ? !dma_we   : !cpu_we;
          state_d      = XFER;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
        end
      end
      XFER: begin
        if (bus_ready) begin
          bus_ren_d = 1'b0;
          bus_wen_d = 1'b0;
          state_d   = DONE;
          if (last_grant_q == GNT_DMA) begin
            dma_ack_d = 1'b1;
            if (bus_ren) dma_rdata_d = bus_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (bus_ren) cpu_rdata_d = bus_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            bus_ren_d = 1'b0;
            bus_wen_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = DONE;
            if (last_grant_q == GNT_DMA) begin
              dma_ack_d   = 1'b1;
              dma_rdata_d = 32'hDEAD_BEEF;
            end else begin
              cpu_ack_d   = 1'b1;
              cpu_rdata_d = 32'hDEAD_BEEF;
            end
          end
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops strobes immediately without an ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DMA;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_ren      <= 1'b0;
      bus_wen      <= 1'b0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_addr     <= bus_addr_d;
      bus_wdata    <= bus_wdata_d;
      bus_ren      <= bus_ren_d;
      bus_wen      <= bus_wen_d;
      cpu_rdata    <= cpu_rdata_d;
      dma_rdata    <= dma_rdata_d;
      cpu_ack      <= cpu_ack_d;
      dma_ack      <= dma_ack_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      bus_err      <= bus_err_d;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter with an expected-transaction queue.
// Builds with or without ARB_TIMEOUT_EN; the timeout step adapts to the macro.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ren, bus_wen, bus_ready, bus_err;

  typedef struct {
    logic        dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          strobes;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_cpu_rdata, m_dma_rdata;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic dma, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err, input int strobes);
    exp_t e;
    e.dma = dma; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.strobes = strobes;
    sb.push_back(e);
  endtask

  // Follows one transfer from grant to ack; ready_at=0 means the slave never answers.
  task automatic run_xfer(input int ready_at, input logic drop, input logic scribble);
    exp_t e;
    int   strobes = 0, bad = 0, ack_at = 0;
    logic got = 1'b0;
    e = sb[0];
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        got = 1'b1;
        ack_at = i;
      end else begin
        if (bus_wen === e.we && bus_ren === !e.we && bus_addr === e.addr &&
            (!e.we || bus_wdata === e.wdata))
          strobes++;
        else
          bad++;
        if (i == ready_at) bus_ready = 1'b1;
        if (scribble) begin
          dma_addr = 32'hFFFF_0000 + 32'(i); dma_wdata = 32'(i);
          cpu_addr = 32'hEEEE_0000 + 32'(i); cpu_wdata = 32'(i);
        end
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      void'(sb.pop_front());
      if (e.err || !e.we) begin
        if (e.dma) m_dma_rdata = e.rdata;
        else       m_cpu_rdata = e.rdata;
      end
      chk("ack_owner", 32'({dma_ack, cpu_ack}), e.dma ? 32'd2 : 32'd1);
      chk("strobe_cycles", 32'(strobes), 32'(e.strobes));
      chk("bad_strobe_cycles", 32'(bad), 32'd0);
      chk("ack_latency", 32'(ack_at), 32'(e.strobes + 1));
      chk("bus_err", 32'(bus_err), 32'(e.err));
      chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk("dma_rdata", dma_rdata, m_dma_rdata);
      bus_ready = 1'b0;
      if (drop) begin
        if (e.dma) dma_req = 1'b0;
        else       cpu_req = 1'b0;
      end
      @(negedge clk);
      chk("ack_pulse_end", 32'({dma_ack, cpu_ack, bus_ren, bus_wen, bus_err}), 32'd0);
    end
  endtask

  initial begin
    int ren_cycles, ack_cycles;
    resetn = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    bus_rdata = '0; bus_ready = 0;
    m_cpu_rdata = '0; m_dma_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({bus_ren, bus_wen, cpu_ack, dma_ack, bus_err}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // CPU read, slave ready immediately
    cpu_we = 0; cpu_addr = 32'h0000_0100; bus_rdata = 32'h1234_5678; cpu_req = 1;
    push(0, 0, 32'h0000_0100, '0, 32'h1234_5678, 0, 1);
    run_xfer(1, 1, 0);

    // bus_ready while idle does nothing
    bus_ready = 1;
    repeat (3) @(negedge clk);
    chk("idle_ready_ignored", 32'({bus_ren, bus_wen, cpu_ack, dma_ack}), 32'd0);
    bus_ready = 0;

    // DMA write, ready after 5 wait cycles; requester inputs scribbled during XFER
    dma_we = 1; dma_addr = 32'h0001_0000; dma_wdata = 32'hCAFE_F00D; dma_req = 1;
    push(1, 1, 32'h0001_0000, 32'hCAFE_F00D, '0, 0, 6);
    run_xfer(6, 1, 1);

    // CPU write leaves cpu_rdata unchanged
    cpu_we = 1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h55AA_55AA; cpu_req = 1;
    push(0, 1, 32'h0000_2000, 32'h55AA_55AA, '0, 0, 3);
    run_xfer(3, 1, 0);

    // DMA read
    dma_we = 0; dma_addr = 32'h0000_3000; bus_rdata = 32'hA5A5_0001; dma_req = 1;
    push(1, 0, 32'h0000_3000, '0, 32'hA5A5_0001, 0, 2);
    run_xfer(2, 1, 0);

    // Both requesting from reset: CPU, DMA, CPU, DMA, then CPU alone
    resetn = 0;
    m_cpu_rdata = '0; m_dma_rdata = '0;
    cpu_we = 0; cpu_addr = 32'h0000_0300;
    dma_we = 1; dma_addr = 32'h0000_0400; dma_wdata = 32'h1111_2222;
    cpu_req = 1; dma_req = 1;
    @(negedge clk);
    resetn = 1;
    bus_rdata = 32'h0000_00C1;
    push(0, 0, 32'h0000_0300, '0, 32'h0000_00C1, 0, 1);
    run_xfer(1, 0, 0);
    push(1, 1, 32'h0000_0400, 32'h1111_2222, '0, 0, 1);
    run_xfer(1, 0, 0);
    bus_rdata = 32'h0000_00C2;
    push(0, 0, 32'h0000_0300, '0, 32'h0000_00C2, 0, 1);
    run_xfer(1, 0, 0);
    push(1, 1, 32'h0000_0400, 32'h1111_2222, '0, 0, 1);
    run_xfer(1, 1, 0);
    bus_rdata = 32'h0000_00C3;
    push(0, 0, 32'h0000_0300, '0, 32'h0000_00C3, 0, 1);
    run_xfer(1, 1, 0);

    // Reset during CPU XFER: strobes drop at once, no ack, CPU wins next tie
    cpu_we = 0; cpu_addr = 32'h0000_0500; bus_ready = 0; cpu_req = 1;
    @(negedge clk);
    chk("pre_rst_ren", 32'({bus_ren, bus_wen}), 32'd2);
    @(negedge clk);
    chk("pre_rst_ren_hold", 32'({bus_ren, bus_wen}), 32'd2);
    resetn = 0;
    #1;
    chk("rst_strobes_drop", 32'({bus_ren, bus_wen, cpu_ack, dma_ack}), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    m_cpu_rdata = '0; m_dma_rdata = '0;
    dma_we = 0; dma_addr = 32'h0000_0600; dma_req = 1;
    @(negedge clk);
    chk("rst_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
    resetn = 1;
    bus_rdata = 32'hBEEF_0001;
    push(0, 0, 32'h0000_0500, '0, 32'hBEEF_0001, 0, 1);
    run_xfer(1, 1, 0);
    bus_rdata = 32'h0BAD_F00D;
    push(1, 0, 32'h0000_0600, '0, 32'h0BAD_F00D, 0, 1);
    run_xfer(1, 1, 0);

    // Slave never answers
    cpu_we = 0; cpu_addr = 32'h0000_0700; bus_ready = 0; cpu_req = 1;
`ifdef ARB_TIMEOUT_EN
    push(0, 0, 32'h0000_0700, '0, 32'hDEAD_BEEF, 1, 4);
    run_xfer(0, 1, 0);
`else
    ren_cycles = 0; ack_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_ren) ren_cycles++;
      if (cpu_ack || dma_ack || bus_err) ack_cycles++;
    end
    chk("no_timeout_ren_cycles", 32'(ren_cycles), 32'd30);
    chk("no_timeout_acks", 32'(ack_cycles), 32'd0);
    resetn = 0; cpu_req = 0;
    @(negedge clk);
    resetn = 1;
`endif
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
